seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 147 ++++++++++++++
 tb/tb_seq_divider.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider
//   Unsigned sequential divider, radix-2 restoring, one quotient bit per clock.
//   A division by zero completes immediately with quotient = all ones,
//   remainder = dividend and div_by_zero set.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for operands, in_ready high
//   BUSY  | iterating, WIDTH restoring steps MSB-first
//   DONE  | result held on the outputs, out_valid high until taken
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_valid     operands present        in_ready   operands accepted (IDLE)
//   dividend     unsigned numerator      divisor    unsigned denominator
//   out_valid    result present (DONE)   out_ready  consumer takes result
//   quotient     registered quotient     remainder  registered remainder
//   div_by_zero  registered zero-divisor flag for the held result
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder
    logic [WIDTH-1:0] acc_q, acc_d;     // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs_q, dvs_d;     // captured divisor
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_acc;
    logic             last_step;

    // The partial remainder is always below the divisor, so the shifted value
    // is below 2*divisor: a non-borrowing difference fits in WIDTH bits and a
    // borrowing one wraps with bit WIDTH set, making that bit the borrow.
    always_comb begin
        shifted   = {rem_q, acc_q[WIDTH-1]};
        trial     = shifted - {1'b0, dvs_q};
        borrow    = trial[WIDTH];
        step_rem  = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        step_acc  = {acc_q[WIDTH-2:0], ~borrow};
        last_step = (cnt_q == CW'(WIDTH - 1));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        acc_d   = acc_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_d = dividend;
                    dvs_d = divisor;
                    rem_d = '0;
                    cnt_d = '0;
                    if (divisor == '0) begin
                        quo_d   = '1;
                        rmd_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                rem_d = step_rem;
                acc_d = step_acc;
                cnt_d = cnt_q + CW'(1);
                if (last_step) begin
                    quo_d   = step_acc;
                    rmd_d   = step_rem;
                    dbz_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            acc_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            acc_q   <= acc_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } vec_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == 0) begin
            e.q = '1; e.r = a; e.dbz = 1'b1;
        end else begin
            e.q = a / b; e.r = a % b; e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Pop the oldest expectation and compare against the held outputs.
    task automatic check_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_quotient"}, quotient, e.q);
            chk({tag, "_remainder"}, remainder, e.r);
            chk({tag, "_dbz"}, div_by_zero, e.dbz);
        end
    endtask

    // Accept one operand pair and wait (bounded) for out_valid; returns at the
    // negedge where out_valid is first seen, with out_ready still low.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input exp_t e, input int exp_lat, input string tag);
        int lat;
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        chk({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk);
        sb.push_back(e);
        #1;
        in_valid = 1'b0;
        dividend = ~a;
        divisor  = ~b;
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        check_out(tag);
    endtask

    task automatic finish_op(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_out_valid_drop"}, out_valid, 0);
        chk({tag, "_in_ready_rise"}, in_ready, 1);
        out_ready = 1'b0;
    endtask

    vec_t vecs[8];

    initial begin
        exp_t e;
        int   done_cnt;
        int   cyc;
        bit   new_ops;

        vecs[0] = '{a: 100, b: 7,   q: 14,  r: 2,   dbz: 0};
        vecs[1] = '{a: 5,   b: 0,   q: 255, r: 5,   dbz: 1};
        vecs[2] = '{a: 3,   b: 200, q: 0,   r: 3,   dbz: 0};
        vecs[3] = '{a: 255, b: 1,   q: 255, r: 0,   dbz: 0};
        vecs[4] = '{a: 0,   b: 5,   q: 0,   r: 0,   dbz: 0};
        vecs[5] = '{a: 255, b: 255, q: 1,   r: 0,   dbz: 0};
        vecs[6] = '{a: 254, b: 255, q: 0,   r: 254, dbz: 0};
        vecs[7] = '{a: 0,   b: 0,   q: 255, r: 0,   dbz: 1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_quotient", quotient, 0);
        chk("reset_remainder", remainder, 0);
        chk("reset_dbz", div_by_zero, 0);

        // Directed table: latency is counted in edges after the accept edge;
        // a zero divisor is resolved by the accept edge itself.
        for (int i = 0; i < 8; i++) begin
            e.q = vecs[i].q; e.r = vecs[i].r; e.dbz = vecs[i].dbz;
            run_op(vecs[i].a, vecs[i].b, e, vecs[i].dbz ? 0 : W, $sformatf("vec%0d", i));
            finish_op($sformatf("vec%0d", i));
        end

        // Backpressure: result held, in_valid ignored while DONE.
        e.q = 14; e.r = 2; e.dbz = 0;
        run_op(100, 7, e, W, "bp");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_quotient", quotient, 14);
            chk("bp_remainder", remainder, 2);
            in_valid = 1'b1;
            dividend = 8'd9;
            divisor  = 8'd3;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_out_valid", out_valid, 0);
        chk("bp_release_in_ready", in_ready, 1);
        chk("bp_retain_quotient", quotient, 14);
        chk("bp_retain_remainder", remainder, 2);
        out_ready = 1'b0;

        // Reset on the 4th BUSY edge discards the division.
        @(negedge clk);
        dividend = 100; divisor = 7; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_in_ready", in_ready, 1);
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_quotient", quotient, 0);
        chk("rst_mid_remainder", remainder, 0);
        chk("rst_mid_dbz", div_by_zero, 0);
        repeat (10) @(negedge clk);
        chk("rst_mid_no_result", out_valid, 0);
        e.q = 22; e.r = 2; e.dbz = 0;
        run_op(200, 9, e, W, "post_rst");
        finish_op("post_rst");

        // Randomized back-to-back run with random backpressure.
        done_cnt = 0;
        cyc      = 0;
        new_ops  = 1'b1;
        while ((done_cnt < 1000 || sb.size() != 0) && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            if (new_ops) begin
                dividend = W'($urandom);
                case ($urandom_range(0, 7))
                    0:       divisor = '0;
                    1:       divisor = W'($urandom_range(1, 3));
                    default: divisor = W'($urandom);
                endcase
                new_ops = 1'b0;
            end
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (done_cnt < 1000);
            if (out_valid && out_ready) begin
                check_out("rand");
                done_cnt++;
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(dividend, divisor));
                new_ops = 1'b1;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("rand_ops_completed", (done_cnt >= 1000) ? 1 : 0, 1);
        chk("rand_sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
